fft_bfly_pipe: RTL
==================

Name: fft_bfly_pipe

Overview:
- Pipelined, time-multiplexed radix-2 DIT butterfly for the FFT datapath. Each accepted transaction is one complex pair (a, b), a twiddle index k and a scale mode.
- Computes x0 = a + W^k·b and x1 = a − W^k·b, where W^k = cos(2πk/N) − j·sin(2πk/N).
- Has its own twiddle ROM, valid/ready handshake with backpressure, optional per-stage scaling, saturation with a sticky overflow flag, and tag passthrough.
- The FFT stage controller drives it once per butterfly. It replaces the fully unrolled combinational butterfly array.

Parameters:
- N, 16, FFT size; power of 2, ≥4. The ROM holds N/2 entries; k is $clog2(N/2) bits.
- W, 16, data width per real/imag component, signed two's complement.
- TW, 16, twiddle width, signed Q1.(TW−1).
- TAGW, 8, width of the opaque tag carried with each transaction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_a_re, in_a_im  in  W each  operand a
- in_b_re, in_b_im  in  W each  operand b
- in_k  in  $clog2(N/2)  twiddle index
- in_scale  in  1  1 = divide results by 2
- in_tag  in  TAGW  passthrough tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_x0_re, out_x0_im, out_x1_re, out_x1_im  out  W each  results
- out_tag  out  TAGW  tag of the result
- ovf  out  1  sticky saturation flag
- clr_ovf  in  1  clears ovf

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. All stage valid bits, out_valid, every output data field, out_tag and ovf go to 0. Reset mid-operation discards all in-flight transactions. in_ready is 1 in the first cycle after rst deasserts.
- Twiddle ROM:
  - Built at elaboration. cos_k = round(cos(2πk/N)·(2^(TW−1)−1)), sin_k = round(sin(2πk/N)·(2^(TW−1)−1)).
  - k = 0 therefore gives cos = 2^(TW−1)−1, which is slight attenuation, not exactly 1.
- Pipeline, fixed latency 3 cycles from handshake to out_valid:
  - S1 registers the operands, the ROM lookup, scale and tag.
  - S2 computes the products:
    - pr = b_re·cos + b_im·sin
    - pi = b_im·cos − b_re·sin
    - Each is (W+TW+1)-bit signed, then rounded: (p + 2^(TW−2)) >>> (TW−1). This is round-half-up, arithmetic shift.
    - The result is registered in W+1 bits.
  - S3 forms sums and differences in W+2 bits:
    - s0 = a + g, s1 = a − g.
    - If scale = 1: r = (s + 1) >>> 1.
    - Otherwise r = s.
    - r is saturated to [−2^(W−1), 2^(W−1)−1], then registered to the outputs.
- Overflow flag:
  - ovf sets in the cycle a result is registered into the output stage with any of its 4 components saturated.
  - It stays set until clr_ovf is asserted.
  - If a saturation occurs in the same cycle as clr_ovf, the set wins.
- Handshake:
  - Input is accepted when in_valid && in_ready. Output is transferred when out_valid && out_ready.
  - stall = out_valid && !out_ready, and in_ready = !stall. This is a combinational path from out_ready to in_ready, which is allowed.
  - While stalled, all stages hold and the output data and tag are stable.
  - When not stalled, every stage advances. Bubbles (stage valid = 0) propagate.
  - Full throughput is 1 transaction per cycle.
  - out_valid deasserts only after a transfer with no new data behind it.
- Simultaneous events:
  - Accept-and-emit in the same cycle is normal streaming.
  - in_valid while stalled is simply not accepted; the source holds its data.
- Ordering: strict in-order. out_tag always equals the in_tag of the same transaction.

Decomposition:
- Package fft_pkg holds:
  - a complex struct type parametrised by width
  - the function clog2 helpers
  - the ROM generation function tw_rom_f(N, TW), returning cos/sin arrays
  - the round constants
- Sub-module fft_twiddle_rom: registered synchronous ROM, index → (cos, sin), 1-cycle read aligned with S1.
- The multiply, add and saturate logic stays inline.

Test Plan:
- Pass-through, with N=16, W=16, TW=16: a=(1000,0), b=(200,0), k=0, scale=0 → 3 cycles later x0=(1200,0), x1=(800,0), ovf=0.
- Rotation by −j: a=(1000,0), b=(200,0), k=4 → x0=(1000,−200), x1=(1000,200).
- Saturation: a=(32000,0), b=(32000,0), k=0, scale=0 → x0_re=32767, x1_re=1, ovf=1 and stays 1; the same vector with scale=1 → x0_re=32000, x1_re=1, with no new set; clr_ovf → ovf=0.
- Backpressure: stream 8 tagged transactions tag=0..7 at one per cycle, holding out_ready=0 for cycles 4–7:
  - in_ready drops while out_valid && !out_ready.
  - Output data is stable during the stall.
  - All 8 results emerge in tag order, with none lost or duplicated.
- Reset mid-stream: 3 transactions in flight, then assert rst for 1 cycle → out_valid=0 and ovf=0 the next cycle; no stale result ever appears; a new input gives its result exactly 3 cycles after acceptance.
- Exhaustive twiddle check: for every k in 0..7, b=(16384,0), a=0 → x0 equals the software model of the rounded product, bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 FFT butterfly datapath.
package fft_pkg;

    typedef struct packed {
        int cos_v;
        int sin_v;
    } tw_pair_t;

    localparam real Pi       = 3.14159265358979323846;
    localparam int  ScaleRnd = 1;

    function automatic int unsigned clog2_f(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Half-LSB bias added before dropping the TW-1 fraction bits of a twiddle product.
    function automatic int prod_rnd_f(input int unsigned tw);
        return 1 << (tw - 2);
    endfunction

    function automatic int round_f(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic tw_pair_t tw_rom_f(input int unsigned n, input int unsigned tw,
                                          input int unsigned k);
        real      ang;
        real      amp;
        tw_pair_t p;
        ang     = 2.0 * Pi * real'(k) / real'(n);
        amp     = real'((1 << (tw - 1)) - 1);
        p.cos_v = round_f($cos(ang) * amp);
        p.sin_v = round_f($sin(ang) * amp);
        return p;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Registered twiddle ROM: index -> (cos, sin) in Q1.(TW-1), one-cycle read.
module fft_twiddle_rom import fft_pkg::*; #(
    parameter int unsigned N  = 16,
    parameter int unsigned TW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [$clog2(N/2)-1:0]  k,
    output logic signed [TW-1:0]    cos_q,
    output logic signed [TW-1:0]    sin_q
);

    logic signed [TW-1:0] cos_tab [N/2];
    logic signed [TW-1:0] sin_tab [N/2];

    for (genvar i = 0; i < N / 2; i++) begin : g_tab
        localparam tw_pair_t P = tw_rom_f(N, TW, i);
        assign cos_tab[i] = TW'(P.cos_v);
        assign sin_tab[i] = TW'(P.sin_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cos_q <= '0;
            sin_q <= '0;
        end else if (en) begin
            cos_q <= cos_tab[k];
            sin_q <= sin_tab[k];
        end
    end

endmodule

// File: rtl/fft_bfly_pipe.sv
// Three-stage radix-2 DIT butterfly: x0 = a + W^k*b, x1 = a - W^k*b, with
// optional halving, saturation, sticky overflow and valid/ready backpressure.
module fft_bfly_pipe import fft_pkg::*; #(
    parameter int unsigned N    = 16,
    parameter int unsigned W    = 16,
    parameter int unsigned TW   = 16,
    parameter int unsigned TAGW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a_re,
    input  logic [W-1:0]           in_a_im,
    input  logic [W-1:0]           in_b_re,
    input  logic [W-1:0]           in_b_im,
    input  logic [$clog2(N/2)-1:0] in_k,
    input  logic                   in_scale,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_x0_re,
    output logic [W-1:0]           out_x0_im,
    output logic [W-1:0]           out_x1_re,
    output logic [W-1:0]           out_x1_im,
    output logic [TAGW-1:0]        out_tag,
    output logic                   ovf,
    input  logic                   clr_ovf
);

    localparam int unsigned KW = clog2_f(N / 2);
    localparam int unsigned PW = W + TW + 1;
    localparam int unsigned SW = W + 2;
    localparam logic signed [SW-1:0] MaxV = {{3{1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MinV = {{3{1'b1}}, {(W-1){1'b0}}};

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    logic adv;
    logic acc;

    logic                 v1_q;
    cplx_t                a1_q, b1_q;
    logic                 sc1_q;
    logic [TAGW-1:0]      tag1_q;
    logic signed [TW-1:0] cos1, sin1;

    logic                 v2_q;
    cplx_t                a2_q;
    logic signed [W:0]    g_re2_q, g_im2_q;
    logic                 sc2_q;
    logic [TAGW-1:0]      tag2_q;

    logic signed [PW-1:0] prod_re, prod_im, rnd_re, rnd_im;
    logic signed [SW-1:0] s0_re, s0_im, s1_re, s1_im;
    logic [W:0]           sat0_re, sat0_im, sat1_re, sat1_im;
    logic                 sat_any;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign acc      = in_valid && adv;

    fft_twiddle_rom #(
        .N  (N),
        .TW (TW)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .en    (acc),
        .k     (in_k),
        .cos_q (cos1),
        .sin_q (sin1)
    );

    function automatic logic signed [SW-1:0] scale_f(input logic signed [SW-1:0] s,
                                                     input logic sc);
        return sc ? ((s + SW'(ScaleRnd)) >>> 1) : s;
    endfunction

    // MSB flags saturation, low W bits carry the clamped value.
    function automatic logic [W:0] sat_f(input logic signed [SW-1:0] r);
        if (r > MaxV) return {1'b1, MaxV[W-1:0]};
        if (r < MinV) return {1'b1, MinV[W-1:0]};
        return {1'b0, r[W-1:0]};
    endfunction

    always_comb begin
        prod_re = PW'(b1_q.re) * PW'(cos1) + PW'(b1_q.im) * PW'(sin1);
        prod_im = PW'(b1_q.im) * PW'(cos1) - PW'(b1_q.re) * PW'(sin1);
        rnd_re  = (prod_re + PW'(prod_rnd_f(TW))) >>> (TW - 1);
        rnd_im  = (prod_im + PW'(prod_rnd_f(TW))) >>> (TW - 1);
    end

    always_comb begin
        s0_re   = SW'(a2_q.re) + SW'(g_re2_q);
        s0_im   = SW'(a2_q.im) + SW'(g_im2_q);
        s1_re   = SW'(a2_q.re) - SW'(g_re2_q);
        s1_im   = SW'(a2_q.im) - SW'(g_im2_q);
        sat0_re = sat_f(scale_f(s0_re, sc2_q));
        sat0_im = sat_f(scale_f(s0_im, sc2_q));
        sat1_re = sat_f(scale_f(s1_re, sc2_q));
        sat1_im = sat_f(scale_f(s1_im, sc2_q));
        sat_any = sat0_re[W] | sat0_im[W] | sat1_re[W] | sat1_im[W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            a1_q      <= '0;
            b1_q      <= '0;
            sc1_q     <= 1'b0;
            tag1_q    <= '0;
            v2_q      <= 1'b0;
            a2_q      <= '0;
            g_re2_q   <= '0;
            g_im2_q   <= '0;
            sc2_q     <= 1'b0;
            tag2_q    <= '0;
            out_valid <= 1'b0;
            out_x0_re <= '0;
            out_x0_im <= '0;
            out_x1_re <= '0;
            out_x1_im <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (adv) begin
                v1_q      <= in_valid;
                v2_q      <= v1_q;
                out_valid <= v2_q;
                if (in_valid) begin
                    a1_q   <= '{re: in_a_re, im: in_a_im};
                    b1_q   <= '{re: in_b_re, im: in_b_im};
                    sc1_q  <= in_scale;
                    tag1_q <= in_tag;
                end
                if (v1_q) begin
                    a2_q    <= a1_q;
                    g_re2_q <= rnd_re[W:0];
                    g_im2_q <= rnd_im[W:0];
                    sc2_q   <= sc1_q;
                    tag2_q  <= tag1_q;
                end
                if (v2_q) begin
                    out_x0_re <= sat0_re[W-1:0];
                    out_x0_im <= sat0_im[W-1:0];
                    out_x1_re <= sat1_re[W-1:0];
                    out_x1_im <= sat1_im[W-1:0];
                    out_tag   <= tag2_q;
                end
            end
            // A fresh saturation outranks a simultaneous clear.
            if (adv && v2_q && sat_any) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    logic unused_kw;
    assign unused_kw = (KW == 0);

endmodule
